hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the ID/EX boundary. Detects load-use and HI/LO
//  hazards, stalls PC and IF/ID, injects bubbles into the ID/EX control_signals,
//  flushes IF/ID on taken branches and selects forwarding sources for ALU operand A/B.
//  Owns the multi-cycle mult/div occupancy FSM that governs HI/LO write timing.
// PARAMETERS
//  MULDIV_LAT  4   cycles from mult/div issue to hilo_we pulse (legal range 2..15)
//  STALL_CW    16  width of the saturating stall statistics counter
// PORTS
//  clk            in   1   rising-edge clock
//  reset_n        in   1   synchronous reset, active low
//  ID_rs          in   5   ID source register A
//  ID_rt          in   5   ID source register B
//  ID_uses_rs     in   1   ID instruction reads rs
//  ID_uses_rt     in   1   ID instruction reads rt
//  ID_muldiv      in   1   ID instruction is mult/multu/div/divu
//  ID_reads_hilo  in   1   ID instruction is mfhi/mflo
//  EX_load        in   1   EX holds a load (load_instr_reg)
//  EX_rf_enable   in   1   EX writes the register file
//  EX_dest        in   5   EX destination register
//  EX_branch_taken in  1   condition handler resolved a taken branch/jump in EX
//  MEM_rf_enable  in   1   MEM writes the register file
//  MEM_dest       in   5   MEM destination register
//  WB_rf_enable   in   1   WB writes the register file
//  WB_dest        in   5   WB destination register
//  pc_enable      out  1   PC load enable
//  ifid_enable    out  1   IF/ID register load enable
//  ifid_flush     out  1   clear IF/ID to NOP
//  idex_bubble    out  1   force ID/EX control_signals to 22'b0
//  fwd_a_sel      out  2   operand A source: 00 RF, 01 EX, 10 MEM, 11 WB
//  fwd_b_sel      out  2   operand B source, same encoding
//  muldiv_busy    out  1   mult/div unit occupied
//  hilo_we        out  1   one-cycle HI/LO write strobe
//  stall_count    out  STALL_CW  cycles stalled since reset, saturating
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): state=IDLE, cnt=0, muldiv_busy=0, hilo_we=0,
//    stall_count=0. Combinational outputs then follow IDLE rules below.
//  - Forwarding (combinational): for each operand, EX match (EX_rf_enable, EX_dest!=0,
//    EX_dest==src, !EX_load) -> 01; else MEM match -> 10; else WB match -> 11; else 00.
//    Priority EX > MEM > WB. R0 never forwarded.
//  - load_stall = EX_load & EX_rf_enable & EX_dest!=0 &
//    ((ID_uses_rs & EX_dest==ID_rs) | (ID_uses_rt & EX_dest==ID_rt)).
//  - hilo_stall = muldiv_busy & (ID_reads_hilo | ID_muldiv).
//  - stall = load_stall | hilo_stall -> pc_enable=0, ifid_enable=0, idex_bubble=1.
//  - EX_branch_taken -> ifid_flush=1, pc_enable=1 (target load) regardless of stall;
//    idex_bubble then also asserted if stall. ifid_enable=1 when flushing.
//  - FSM states: IDLE, BUSY.
//    IDLE -> BUSY when ID_muldiv & !load_stall & !EX_branch_taken; cnt <= MULDIV_LAT-1.
//    BUSY: cnt decrements each cycle; when cnt==1, hilo_we<=1 next cycle and state->IDLE.
//    hilo_we is high exactly one cycle, MULDIV_LAT cycles after the issue edge.
//    muldiv_busy = (state==BUSY), registered.
//  - A mult/div stalled by hilo_stall issues on the cycle after return to IDLE
//    (back-to-back issue spacing = MULDIV_LAT+1 cycles).
//  - Reset mid-BUSY abandons the operation: no hilo_we pulse is produced.
//  - stall_count increments on every edge where stall=1; holds at all-ones.
// TESTING
//  - lw $5 in EX, add $6,$5,$7 in ID -> 1 cycle pc_enable=0, idex_bubble=1; next cycle fwd_a_sel=10.
//  - EX writes $3, MEM writes $3, ID reads rs=$3 -> fwd_a_sel=01; ID reads $0 -> 00.
//  - mult issued at cycle 0 -> muldiv_busy 1..4, hilo_we high only at cycle 4; mflo in ID
//    during busy stalls until cycle 5.
//  - EX_branch_taken with hilo_stall -> ifid_flush=1, pc_enable=1, idex_bubble=1.
//  - reset_n=0 at cycle 2 of BUSY -> muldiv_busy=0, no hilo_we, stall_count=0.
//  - force 2^16+3 stall cycles -> stall_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Bundle between the ID/EX hazard controller and the pipeline: stage register
// IDs and enables in, stall/flush/forward controls and mult/div status out.
interface hazard_ctrl_if #(
  parameter int STALL_CW = 16
);
  logic [4:0]          ID_rs;
  logic [4:0]          ID_rt;
  logic                ID_uses_rs;
  logic                ID_uses_rt;
  logic                ID_muldiv;
  logic                ID_reads_hilo;
  logic                EX_load;
  logic                EX_rf_enable;
  logic [4:0]          EX_dest;
  logic                EX_branch_taken;
  logic                MEM_rf_enable;
  logic [4:0]          MEM_dest;
  logic                WB_rf_enable;
  logic [4:0]          WB_dest;
  logic                pc_enable;
  logic                ifid_enable;
  logic                ifid_flush;
  logic                idex_bubble;
  logic [1:0]          fwd_a_sel;
  logic [1:0]          fwd_b_sel;
  logic                muldiv_busy;
  logic                hilo_we;
  logic [STALL_CW-1:0] stall_count;

  modport master (
    output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_muldiv, ID_reads_hilo,
           EX_load, EX_rf_enable, EX_dest, EX_branch_taken,
           MEM_rf_enable, MEM_dest, WB_rf_enable, WB_dest,
    input  pc_enable, ifid_enable, ifid_flush, idex_bubble,
           fwd_a_sel, fwd_b_sel, muldiv_busy, hilo_we, stall_count
  );

  modport slave (
    input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_muldiv, ID_reads_hilo,
           EX_load, EX_rf_enable, EX_dest, EX_branch_taken,
           MEM_rf_enable, MEM_dest, WB_rf_enable, WB_dest,
    output pc_enable, ifid_enable, ifid_flush, idex_bubble,
           fwd_a_sel, fwd_b_sel, muldiv_busy, hilo_we, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ID/EX hazard controller: load-use and HI/LO stalls, branch flush, operand
// forwarding select, and the mult/div occupancy FSM that times the HI/LO write.
module hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int STALL_CW   = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0]          CNT_INIT  = 4'(MULDIV_LAT - 1);
  localparam logic [STALL_CW-1:0] STALL_ONE = STALL_CW'(1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                hilo_we_q, hilo_we_d;
  logic [STALL_CW-1:0] stall_count_q, stall_count_d;

  logic load_stall;
  logic hilo_stall;
  logic stall;

  // EX > MEM > WB; a load still in EX has no data yet, so it never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       ex_en,  input logic [4:0] ex_dest, input logic ex_load,
    input logic       mem_en, input logic [4:0] mem_dest,
    input logic       wb_en,  input logic [4:0] wb_dest
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_en && ex_dest != 5'd0 && ex_dest == src && !ex_load)
      sel = 2'b01;
    else if (mem_en && mem_dest != 5'd0 && mem_dest == src)
      sel = 2'b10;
    else if (wb_en && wb_dest != 5'd0 && wb_dest == src)
      sel = 2'b11;
    return sel;
  endfunction

  always_comb begin
    load_stall = hz.EX_load && hz.EX_rf_enable && (hz.EX_dest != 5'd0) &&
                 ((hz.ID_uses_rs && hz.EX_dest == hz.ID_rs) ||
                  (hz.ID_uses_rt && hz.EX_dest == hz.ID_rt));
    hilo_stall = (state_q == BUSY) && (hz.ID_reads_hilo || hz.ID_muldiv);
    stall      = load_stall || hilo_stall;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hilo_we_d     = 1'b0;
    stall_count_d = stall_count_q;

    if (stall && stall_count_q != '1)
      stall_count_d = stall_count_q + STALL_ONE;

    case (state_q)
      IDLE: begin
        if (hz.ID_muldiv && !load_stall && !hz.EX_branch_taken) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        // Strobe lands in the last busy cycle, so the unit frees one cycle later.
        if (cnt_q == 4'd1)
          hilo_we_d = 1'b1;
        if (cnt_q == 4'd0)
          state_d = IDLE;
        else
          cnt_d = cnt_q - 4'd1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      hilo_we_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hilo_we_q     <= hilo_we_d;
      stall_count_q <= stall_count_d;
    end
  end

  // A taken branch must load its target even while ID is held.
  assign hz.pc_enable   = hz.EX_branch_taken || !stall;
  assign hz.ifid_enable = hz.EX_branch_taken || !stall;
  assign hz.ifid_flush  = hz.EX_branch_taken;
  assign hz.idex_bubble = stall;

  assign hz.fwd_a_sel = fwd_sel(hz.ID_rs, hz.EX_rf_enable, hz.EX_dest, hz.EX_load,
                                hz.MEM_rf_enable, hz.MEM_dest,
                                hz.WB_rf_enable, hz.WB_dest);
  assign hz.fwd_b_sel = fwd_sel(hz.ID_rt, hz.EX_rf_enable, hz.EX_dest, hz.EX_load,
                                hz.MEM_rf_enable, hz.MEM_dest,
                                hz.WB_rf_enable, hz.WB_dest);

  assign hz.muldiv_busy = (state_q == BUSY);
  assign hz.hilo_we     = hilo_we_q;
  assign hz.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected control vectors are queued as each
// step is driven and popped/compared at the following falling edge.
module tb_hazard_ctrl;

  logic clk;
  logic reset_n;

  hazard_ctrl_if #(.STALL_CW(16)) hif ();

  hazard_ctrl #(.MULDIV_LAT(4), .STALL_CW(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total  = 0;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  // {pc_enable, ifid_enable, ifid_flush, idex_bubble, fwd_a, fwd_b, busy, hilo_we}
  function automatic logic [9:0] ev(input logic pc, input logic ifid, input logic fl,
                                    input logic bub, input logic [1:0] fa,
                                    input logic [1:0] fb, input logic busy,
                                    input logic we);
    return {pc, ifid, fl, bub, fa, fb, busy, we};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    logic [9:0] want;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    obs  = {hif.pc_enable, hif.ifid_enable, hif.ifid_flush, hif.idex_bubble,
            hif.fwd_a_sel, hif.fwd_b_sel, hif.muldiv_busy, hif.hilo_we};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s observed=%b expected=%b", t, obs, want);
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    total++;
    assert (hif.stall_count === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, hif.stall_count, exp);
  endtask

  task automatic clr();
    hif.ID_rs = '0;          hif.ID_rt = '0;
    hif.ID_uses_rs = 1'b0;   hif.ID_uses_rt = 1'b0;
    hif.ID_muldiv = 1'b0;    hif.ID_reads_hilo = 1'b0;
    hif.EX_load = 1'b0;      hif.EX_rf_enable = 1'b0;
    hif.EX_dest = '0;        hif.EX_branch_taken = 1'b0;
    hif.MEM_rf_enable = 1'b0; hif.MEM_dest = '0;
    hif.WB_rf_enable = 1'b0;  hif.WB_dest = '0;
  endtask

  task automatic load_use_on();
    hif.EX_load = 1'b1; hif.EX_rf_enable = 1'b1; hif.EX_dest = 5'd5;
    hif.ID_rs = 5'd5;   hif.ID_uses_rs = 1'b1;
  endtask

  initial begin
    clr();
    reset_n = 1'b0;
    cyc();
    cyc();
    step("reset_outputs", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
    chk_cnt("reset_count", 16'h0000);
    reset_n = 1'b1;

    // lw $5 in EX, add $6,$5,$7 in ID
    cyc();
    load_use_on();
    hif.ID_rt = 5'd7; hif.ID_uses_rt = 1'b1;
    step("load_use_stall", ev(0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
    cyc();
    hif.EX_load = 1'b0; hif.EX_rf_enable = 1'b0; hif.EX_dest = 5'd0;
    hif.MEM_rf_enable = 1'b1; hif.MEM_dest = 5'd5;
    step("load_use_fwd_mem", ev(1, 1, 0, 0, 2'b10, 2'b00, 0, 0));
    chk_cnt("count_after_load", 16'd1);

    // forwarding priority
    cyc();
    clr();
    hif.EX_rf_enable = 1'b1;  hif.EX_dest = 5'd3;
    hif.MEM_rf_enable = 1'b1; hif.MEM_dest = 5'd3;
    hif.WB_rf_enable = 1'b1;  hif.WB_dest = 5'd3;
    hif.ID_rs = 5'd3; hif.ID_rt = 5'd3;
    step("fwd_ex_prio", ev(1, 1, 0, 0, 2'b01, 2'b01, 0, 0));
    cyc();
    hif.EX_rf_enable = 1'b0;
    step("fwd_mem_prio", ev(1, 1, 0, 0, 2'b10, 2'b10, 0, 0));
    cyc();
    hif.MEM_rf_enable = 1'b0;
    step("fwd_wb", ev(1, 1, 0, 0, 2'b11, 2'b11, 0, 0));
    cyc();
    hif.EX_rf_enable = 1'b1; hif.MEM_rf_enable = 1'b1;
    hif.ID_rt = 5'd0;
    step("fwd_rs3_rt0", ev(1, 1, 0, 0, 2'b01, 2'b00, 0, 0));
    cyc();
    hif.EX_dest = 5'd0; hif.MEM_dest = 5'd0; hif.WB_dest = 5'd0;
    hif.ID_rs = 5'd0;
    step("fwd_r0_never", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
    cyc();
    clr();
    hif.EX_load = 1'b1; hif.EX_rf_enable = 1'b1; hif.EX_dest = 5'd4;
    hif.MEM_rf_enable = 1'b1; hif.MEM_dest = 5'd4; hif.ID_rs = 5'd4;
    step("load_unused_src_no_stall", ev(1, 1, 0, 0, 2'b10, 2'b00, 0, 0));

    // mult at cycle 0, mflo behind it
    cyc();
    clr();
    hif.ID_muldiv = 1'b1;
    step("mult_issue", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
    cyc();
    hif.ID_muldiv = 1'b0; hif.ID_reads_hilo = 1'b1;
    step("mflo_stall_c1", ev(0, 0, 0, 1, 2'b00, 2'b00, 1, 0));
    cyc();
    step("mflo_stall_c2", ev(0, 0, 0, 1, 2'b00, 2'b00, 1, 0));
    cyc();
    step("mflo_stall_c3", ev(0, 0, 0, 1, 2'b00, 2'b00, 1, 0));
    cyc();
    step("mflo_stall_c4_hilo_we", ev(0, 0, 0, 1, 2'b00, 2'b00, 1, 1));
    cyc();
    step("mflo_release_c5", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
    chk_cnt("count_after_mflo", 16'd5);

    // back-to-back mult: second one waits for the first to drain
    cyc();
    hif.ID_reads_hilo = 1'b0; hif.ID_muldiv = 1'b1;
    step("b2b_first_issue", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
    for (int i = 0; i < 4; i++) begin
      cyc();
      step("b2b_second_held", ev(0, 0, 0, 1, 2'b00, 2'b00, 1, (i == 3)));
    end
    cyc();
    step("b2b_second_issue", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
    cyc();
    hif.ID_muldiv = 1'b0;
    step("b2b_second_busy", ev(1, 1, 0, 0, 2'b00, 2'b00, 1, 0));

    // taken branch while a hilo stall is active
    cyc();
    hif.ID_reads_hilo = 1'b1; hif.EX_branch_taken = 1'b1;
    step("branch_over_hilo_stall", ev(1, 1, 1, 1, 2'b00, 2'b00, 1, 0));
    cyc();
    clr();
    step("busy_no_stall", ev(1, 1, 0, 0, 2'b00, 2'b00, 1, 0));
    cyc();
    step("second_hilo_we", ev(1, 1, 0, 0, 2'b00, 2'b00, 1, 1));

    // a flushed or load-stalled mult must not issue
    cyc();
    hif.ID_muldiv = 1'b1; hif.EX_branch_taken = 1'b1;
    step("mult_under_branch", ev(1, 1, 1, 0, 2'b00, 2'b00, 0, 0));
    cyc();
    clr();
    step("no_issue_after_branch", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
    cyc();
    hif.ID_muldiv = 1'b1;
    load_use_on();
    step("mult_under_load_stall", ev(0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
    cyc();
    clr();
    hif.ID_muldiv = 1'b1;
    step("mult_issue_after_load", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
    chk_cnt("count_before_reset", 16'd11);
    cyc();
    hif.ID_muldiv = 1'b0;
    step("busy_cycle1", ev(1, 1, 0, 0, 2'b00, 2'b00, 1, 0));

    // reset in the second busy cycle abandons the op
    cyc();
    reset_n = 1'b0;
    step("busy_cycle2_reset_low", ev(1, 1, 0, 0, 2'b00, 2'b00, 1, 0));
    cyc();
    reset_n = 1'b1;
    step("after_reset_idle", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
    chk_cnt("count_cleared", 16'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      step("no_hilo_we_after_reset", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
    end

    // saturation of the stall counter
    cyc();
    load_use_on();
    repeat (65534) cyc();
    chk_cnt("count_fffe", 16'hFFFE);
    repeat (5) cyc();
    chk_cnt("count_saturated", 16'hFFFF);
    step("stall_still_active", ev(0, 0, 0, 1, 2'b00, 2'b00, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
